// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state encoding.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RESP    = 3'd5
   } master_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single-beat commands into one AXI write or read
// transaction at a time and returns status and read data on a response port.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_SIZE = 8
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDRESS_SIZE-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic [ADDRESS_SIZE-1:0]   AWADDR,
   output logic                      AWVALID,
   input  logic                      AWREADY,
   output logic [DATA_WIDTH-1:0]     WDATA,
   output logic [DATA_WIDTH/8-1:0]   WSTRB,
   output logic                      WVALID,
   input  logic                      WREADY,
   input  logic [1:0]                BRESP,
   input  logic                      BVALID,
   output logic                      BREADY,
   output logic [ADDRESS_SIZE-1:0]   ARADDR,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   input  logic [DATA_WIDTH-1:0]     RDATA,
   input  logic [1:0]                RRESP,
   input  logic                      RVALID,
   output logic                      RREADY
);

   master_state_t state;
   logic          aw_done;
   logic          w_done;
   logic          aw_hs;
   logic          w_hs;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         AWADDR    <= '0;
         AWVALID   <= 1'b0;
         WDATA     <= '0;
         WSTRB     <= '0;
         WVALID    <= 1'b0;
         BREADY    <= 1'b0;
         ARADDR    <= '0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // cmd_ready is registered, so it first rises one edge after reset release
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     AWADDR  <= cmd_addr;
                     WDATA   <= cmd_wdata;
                     WSTRB   <= cmd_wstrb;
                     AWVALID <= 1'b1;
                     WVALID  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                     state   <= WR_REQ;
                  end else begin
                     ARADDR  <= cmd_addr;
                     ARVALID <= 1'b1;
                     state   <= RD_REQ;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  AWVALID <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  WVALID <= 1'b0;
                  w_done <= 1'b1;
               end
               // either channel may finish first, or both on the same edge
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  BREADY <= 1'b1;
                  state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (BVALID) begin
                  BREADY    <= 1'b0;
                  rsp_err   <= (BRESP != RESP_OKAY);
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RD_REQ: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (RVALID) begin
                  RREADY    <= 1'b0;
                  rsp_rdata <= RDATA;
                  rsp_err   <= (RRESP != RESP_OKAY);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master with a hand-driven AXI slave.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;

   int n_cmp = 0;
   int n_bad = 0;
   int b_hs_cnt = 0;

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) if (BVALID && BREADY) b_hs_cnt <= b_hs_cnt + 1;

   axi_lite_master #(.DATA_WIDTH(32), .ADDRESS_SIZE(8)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      tick();
      // scramble the command port to show fields are sampled only at acceptance
      cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'h0;
   endtask

   task automatic rsp_take();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_after_take", 32'(rsp_valid), 0);
      chk("cmd_ready_after_take", 32'(cmd_ready), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = RESP_OKAY;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = RESP_OKAY;
      #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 0);
      chk("reset_awvalid", 32'(AWVALID), 0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      tick(); tick();
      ARESET = 1'b0;
      chk("cmd_ready_before_first_edge", 32'(cmd_ready), 0);
      tick();
      chk("cmd_ready_after_release", 32'(cmd_ready), 1);

      // Write with an always-ready slave: minimum latency
      AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = RESP_OKAY;
      send(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF);
      chk("wr_awvalid", 32'(AWVALID), 1);
      chk("wr_wvalid", 32'(WVALID), 1);
      chk("wr_awaddr", 32'(AWADDR), 32'h04);
      chk("wr_wdata", WDATA, 32'hDEAD_BEEF);
      chk("wr_wstrb", 32'(WSTRB), 32'hF);
      chk("wr_cmd_ready_busy", 32'(cmd_ready), 0);
      tick();
      chk("wr_awvalid_drop", 32'(AWVALID), 0);
      chk("wr_wvalid_drop", 32'(WVALID), 0);
      chk("wr_bready", 32'(BREADY), 1);
      chk("wr_no_rsp_yet", 32'(rsp_valid), 0);
      tick();
      BVALID = 0; AWREADY = 0; WREADY = 0;
      chk("wr_rsp_valid", 32'(rsp_valid), 1);
      chk("wr_rsp_err", 32'(rsp_err), 0);
      chk("wr_rsp_rdata", rsp_rdata, 0);
      chk("wr_bready_drop", 32'(BREADY), 0);
      chk("wr_b_count", 32'(b_hs_cnt), 1);
      rsp_take();

      // Read with 3 cycles of ARREADY wait, SLVERR response
      send(1'b0, 8'h08, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         chk("rd_arvalid_wait", 32'(ARVALID), 1);
         chk("rd_araddr_wait", 32'(ARADDR), 32'h08);
         tick();
      end
      ARREADY = 1;
      tick();
      ARREADY = 0;
      chk("rd_arvalid_drop", 32'(ARVALID), 0);
      chk("rd_rready", 32'(RREADY), 1);
      RVALID = 1; RDATA = 32'h1234_5678; RRESP = RESP_SLVERR;
      tick();
      RVALID = 0; RDATA = 0;
      chk("rd_rsp_valid", 32'(rsp_valid), 1);
      chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd_rsp_err", 32'(rsp_err), 1);
      chk("rd_rready_drop", 32'(RREADY), 0);
      rsp_take();

      // W handshake 4 cycles before AW
      WREADY = 1;
      send(1'b1, 8'h0C, 32'hA5A5_0001, 4'h3);
      tick();
      WREADY = 0;
      chk("skew1_wvalid_drop", 32'(WVALID), 0);
      for (int i = 0; i < 3; i++) begin
         chk("skew1_awvalid_held", 32'(AWVALID), 1);
         chk("skew1_bready_low", 32'(BREADY), 0);
         tick();
      end
      chk("skew1_awaddr", 32'(AWADDR), 32'h0C);
      AWREADY = 1;
      tick();
      AWREADY = 0;
      chk("skew1_awvalid_drop", 32'(AWVALID), 0);
      chk("skew1_bready", 32'(BREADY), 1);
      BVALID = 1; BRESP = RESP_OKAY;
      tick();
      BVALID = 0;
      chk("skew1_rsp_err", 32'(rsp_err), 0);
      chk("skew1_b_count", 32'(b_hs_cnt), 2);
      rsp_take();

      // AW handshake 4 cycles before W
      AWREADY = 1;
      send(1'b1, 8'h10, 32'h0BAD_F00D, 4'hC);
      tick();
      AWREADY = 0;
      chk("skew2_awvalid_drop", 32'(AWVALID), 0);
      for (int i = 0; i < 3; i++) begin
         chk("skew2_wvalid_held", 32'(WVALID), 1);
         chk("skew2_wdata_held", WDATA, 32'h0BAD_F00D);
         tick();
      end
      WREADY = 1;
      tick();
      WREADY = 0;
      chk("skew2_wvalid_drop", 32'(WVALID), 0);
      chk("skew2_bready", 32'(BREADY), 1);
      BVALID = 1; BRESP = RESP_OKAY;
      tick();
      BVALID = 0;
      chk("skew2_rsp_err", 32'(rsp_err), 0);
      chk("skew2_b_count", 32'(b_hs_cnt), 3);
      rsp_take();

      // Response backpressure with a second command waiting
      AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = RESP_DECERR;
      send(1'b1, 8'h14, 32'h1, 4'h1);
      tick(); tick();
      BVALID = 0; AWREADY = 0; WREADY = 0;
      chk("bp_rsp_err_decerr", 32'(rsp_err), 1);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20;
      for (int i = 0; i < 5; i++) begin
         chk("bp_cmd_ready_low", 32'(cmd_ready), 0);
         chk("bp_rsp_valid_held", 32'(rsp_valid), 1);
         chk("bp_arvalid_idle", 32'(ARVALID), 0);
         tick();
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("bp_cmd_ready_after_take", 32'(cmd_ready), 1);
      chk("bp_not_yet_accepted", 32'(ARVALID), 0);
      tick();
      cmd_valid = 0;
      chk("bp_second_accepted", 32'(ARVALID), 1);
      chk("bp_second_araddr", 32'(ARADDR), 32'h20);
      ARREADY = 1;
      tick();
      ARREADY = 0;
      RVALID = 1; RDATA = 32'hCAFE_0042; RRESP = RESP_OKAY;
      tick();
      RVALID = 0;
      chk("bp_rd_rdata", rsp_rdata, 32'hCAFE_0042);
      chk("bp_rd_err", 32'(rsp_err), 0);
      rsp_take();

      // Reset in the middle of a write request
      send(1'b1, 8'h30, 32'h5555_AAAA, 4'hF);
      chk("rst_awvalid_before", 32'(AWVALID), 1);
      #1 ARESET = 1'b1;
      #1;
      chk("rst_awvalid_async", 32'(AWVALID), 0);
      chk("rst_wvalid_async", 32'(WVALID), 0);
      chk("rst_cmd_ready_async", 32'(cmd_ready), 0);
      chk("rst_awaddr_clear", 32'(AWADDR), 0);
      tick(); tick();
      ARESET = 1'b0;
      tick();
      chk("rst_no_rsp", 32'(rsp_valid), 0);
      chk("rst_cmd_ready_back", 32'(cmd_ready), 1);
      chk("rst_b_count", 32'(b_hs_cnt), 4);
      ARREADY = 1; RVALID = 1; RDATA = 32'h0F0F_1234; RRESP = RESP_EXOKAY;
      send(1'b0, 8'h40, 32'h0, 4'h0);
      tick();
      ARREADY = 0;
      tick();
      RVALID = 0;
      chk("post_rst_rsp_valid", 32'(rsp_valid), 1);
      chk("post_rst_rdata", rsp_rdata, 32'h0F0F_1234);
      chk("post_rst_err_exokay", 32'(rsp_err), 1);
      rsp_take();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

- AXI4-Lite initiator: turns single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions and returns status/read data on a response port.
- Drives the slave side of the memory-mapped peripherals (the adder and its siblings) from test logic or a control sequencer.
- One transaction in flight at a time.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDRESS_SIZE, 8, address width in bits.

Ports:
- ACLK  in  1  global clock; all logic on its rising edge.
- ARESET  in  1  global reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_SIZE  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  BRESP/RRESP was not OKAY.
- AWADDR  out  ADDRESS_SIZE; AWVALID  out  1; AWREADY  in  1.
- WDATA  out  DATA_WIDTH; WSTRB  out  DATA_WIDTH/8; WVALID  out  1; WREADY  in  1.
- BRESP  in  2; BVALID  in  1; BREADY  out  1.
- ARADDR  out  ADDRESS_SIZE; ARVALID  out  1; ARREADY  in  1.
- RDATA  in  DATA_WIDTH; RRESP  in  2; RVALID  in  1; RREADY  out  1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_addr, cmd_wdata and cmd_wstrb into AWADDR/WDATA/WSTRB or ARADDR.
  - Go to WR_REQ or RD_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together.
  - Each drops independently on its own handshake. Flags aw_done and w_done record completion, so either order or the same cycle is legal.
  - When both handshakes have completed, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID: rsp_err = (BRESP != 2'b00), rsp_rdata = 0, go to RESP.
- RD_REQ:
  - ARVALID=1.
  - On ARREADY, go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID: capture RDATA into rsp_rdata, rsp_err = (RRESP != 2'b00), go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
- AXI rules:
  - Once a VALID is asserted, it and its payload are held until the handshake completes.
  - VALID never depends combinationally on READY.
- Command fields are sampled only at acceptance. Later changes on the command port are ignored.
- Reset:
  - All outputs go to 0 immediately (asynchronous), including cmd_ready.
  - State returns to IDLE; address, data and strobe registers clear.
  - A transaction in progress is abandoned and produces no response.

## Timing
- All outputs are registered.
- cmd_ready rises on the first ACLK edge after ARESET deasserts.
- Minimum write latency, with cmd accepted at edge 0 and a slave that is always ready:
  - AW/W handshake at edge 1.
  - BREADY high from edge 1; B handshake at edge 2.
  - rsp_valid high after edge 2.
- Minimum read latency: AR handshake at edge 1, R handshake at edge 2, rsp_valid high after edge 2.
- Back-to-back: after the rsp handshake at edge N, cmd_ready is high after edge N; the next command cannot be accepted before edge N+1.
- AW/W skew:
  - If AWREADY arrives k cycles before WREADY, AWVALID drops after its handshake and WVALID stays high until its own.
  - WR_RESP is entered on the edge that completes the later handshake.
- BVALID or RVALID asserted early is held by the slave; the block samples it only in WR_RESP or RD_DATA.
- rsp_ready held low keeps the block in RESP indefinitely, with no AXI activity and cmd_ready=0.

## Structure
- Shared package axi_lite_pkg, reused by the slaves:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Master state enum.
- No sub-module: single FSM plus datapath registers, about 200 lines.

## Test plan
- Write, slave always ready, addr 0x04, data 0xDEADBEEF, strb 0xF, BRESP 00 -> AWADDR=0x04 and WDATA=0xDEADBEEF on edge 1; rsp_valid after edge 2; rsp_err=0, rsp_rdata=0.
- Read addr 0x08, slave returns RDATA 0x12345678 with RRESP 10 after 3 wait cycles -> rsp_rdata=0x12345678, rsp_err=1; ARVALID held stable during the wait.
- Write with WREADY 4 cycles before AWREADY, then the reverse -> each VALID drops only on its own handshake; exactly one B handshake; rsp_err=0.
- Response backpressure: rsp_ready low 5 cycles, with cmd_valid high carrying a second command -> cmd_ready stays 0; second command accepted the cycle after the rsp handshake.
- ARESET asserted during WR_REQ with AWVALID high -> AWVALID, WVALID and cmd_ready go to 0 immediately; no rsp_valid; after release, a fresh read completes normally.
